// File: rtl/calc_sequencer_if.sv
// Key-strobe and display bundle between the key classifier, calc_sequencer
// and the display driver. The classifier drives the master side.
interface calc_sequencer_if #(
  parameter int RES_W = 15
);
  // key_valid is a one-cycle strobe with no ready/back-pressure: every key
  // field is qualified by key_valid and is consumed on the rising edge where
  // key_valid=1; the sequencer always accepts, so there is no stall path.
  logic             key_valid;
  logic [3:0]       key_pressed;
  logic             is_number;
  logic             is_op;
  logic             is_c;
  logic             is_equ;
  logic [1:0]       operator;
  logic [RES_W-1:0] disp_value;
  logic             disp_neg;
  logic             result_valid;
  logic [1:0]       state;

  modport master (
    output key_valid, key_pressed, is_number, is_op, is_c, is_equ, operator,
    input  disp_value, disp_neg, result_valid, state
  );

  modport slave (
    input  key_valid, key_pressed, is_number, is_op, is_c, is_equ, operator,
    output disp_value, disp_neg, result_valid, state
  );
endinterface

// File: rtl/calc_sequencer.sv
// Keypad calculator sequencer: operand A / operator / operand B / result entry
// with add and magnitude-plus-sign subtract, all outputs registered.
module calc_sequencer #(
  parameter int DIGITS = 4,
  parameter int RES_W  = 15
) (
  input logic            clk,
  input logic            rst_n,
  calc_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_A   = 2'b00,
    S_OP  = 2'b01,
    S_B   = 2'b10,
    S_RES = 2'b11
  } state_t;

  localparam int               MAX_OP_INT = (10 ** DIGITS) - 1;
  localparam logic [RES_W-1:0] MAX_OP     = MAX_OP_INT[RES_W-1:0];
  localparam logic [RES_W-1:0] TEN        = RES_W'(10);
  localparam logic [2:0]       DIGITS_C   = 3'(DIGITS);

  state_t           r_state,  w_state_nxt;
  logic [RES_W-1:0] r_a,      w_a_nxt;
  logic [RES_W-1:0] r_b,      w_b_nxt;
  logic             r_op,     w_op_nxt;
  logic [2:0]       r_cnt,    w_cnt_nxt;
  logic [RES_W-1:0] r_res,    w_res_nxt;
  logic             r_neg,    w_neg_nxt;
  logic [RES_W-1:0] r_disp_value,   w_disp_value_nxt;
  logic             r_disp_neg,     w_disp_neg_nxt;
  logic             r_result_valid, w_result_valid_nxt;

  logic [RES_W-1:0] w_digit;
  logic [RES_W-1:0] w_a_acc;
  logic [RES_W-1:0] w_b_acc;
  logic             w_cnt_ok;
  logic             w_a_ge_b;
  logic [RES_W-1:0] w_sum;
  logic [RES_W-1:0] w_diff;
  logic             w_op_sub;
  logic             w_chain_ok;

  assign w_digit    = {{(RES_W-4){1'b0}}, bus.key_pressed};
  assign w_a_acc    = (r_a * TEN) + w_digit;
  assign w_b_acc    = (r_b * TEN) + w_digit;
  assign w_cnt_ok   = (r_cnt < DIGITS_C);
  assign w_a_ge_b   = (r_a >= r_b);
  assign w_sum      = r_a + r_b;
  // Subtract is kept as magnitude plus sign so nothing ever wraps.
  assign w_diff     = w_a_ge_b ? (r_a - r_b) : (r_b - r_a);
  assign w_op_sub   = (bus.operator == 2'b10);
  assign w_chain_ok = !r_neg && (r_res <= MAX_OP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_A;
      r_a            <= '0;
      r_b            <= '0;
      r_op           <= 1'b0;
      r_cnt          <= '0;
      r_res          <= '0;
      r_neg          <= 1'b0;
      r_disp_value   <= '0;
      r_disp_neg     <= 1'b0;
      r_result_valid <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_a            <= w_a_nxt;
      r_b            <= w_b_nxt;
      r_op           <= w_op_nxt;
      r_cnt          <= w_cnt_nxt;
      r_res          <= w_res_nxt;
      r_neg          <= w_neg_nxt;
      r_disp_value   <= w_disp_value_nxt;
      r_disp_neg     <= w_disp_neg_nxt;
      r_result_valid <= w_result_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_a_nxt            = r_a;
    w_b_nxt            = r_b;
    w_op_nxt           = r_op;
    w_cnt_nxt          = r_cnt;
    w_res_nxt          = r_res;
    w_neg_nxt          = r_neg;
    w_disp_value_nxt   = r_disp_value;
    w_disp_neg_nxt     = r_disp_neg;
    w_result_valid_nxt = 1'b0;

    if (bus.key_valid) begin
      if (bus.is_c) begin
        w_state_nxt      = S_A;
        w_a_nxt          = '0;
        w_b_nxt          = '0;
        w_op_nxt         = 1'b0;
        w_cnt_nxt        = '0;
        w_res_nxt        = '0;
        w_neg_nxt        = 1'b0;
        w_disp_value_nxt = '0;
        w_disp_neg_nxt   = 1'b0;
      end else if (bus.is_equ) begin
        if (r_state == S_B) begin
          w_state_nxt        = S_RES;
          w_res_nxt          = r_op ? w_diff : w_sum;
          w_neg_nxt          = r_op && !w_a_ge_b;
          w_disp_value_nxt   = r_op ? w_diff : w_sum;
          w_disp_neg_nxt     = r_op && !w_a_ge_b;
          w_result_valid_nxt = 1'b1;
        end
      end else if (bus.is_op) begin
        case (r_state)
          S_A, S_OP: begin
            w_op_nxt    = w_op_sub;
            w_state_nxt = S_OP;
          end
          S_RES: begin
            // Chaining only when the result fits as a fresh operand A.
            if (w_chain_ok) begin
              w_a_nxt     = r_res;
              w_op_nxt    = w_op_sub;
              w_state_nxt = S_OP;
            end
          end
          default: ;
        endcase
      end else if (bus.is_number) begin
        case (r_state)
          S_A: begin
            if (w_cnt_ok) begin
              w_a_nxt          = w_a_acc;
              w_cnt_nxt        = r_cnt + 3'd1;
              w_disp_value_nxt = w_a_acc;
            end else begin
              w_disp_value_nxt = r_a;
            end
          end
          S_OP: begin
            w_b_nxt          = w_digit;
            w_cnt_nxt        = 3'd1;
            w_state_nxt      = S_B;
            w_disp_value_nxt = w_digit;
          end
          S_B: begin
            if (w_cnt_ok) begin
              w_b_nxt          = w_b_acc;
              w_cnt_nxt        = r_cnt + 3'd1;
              w_disp_value_nxt = w_b_acc;
            end else begin
              w_disp_value_nxt = r_b;
            end
          end
          S_RES: begin
            w_a_nxt          = w_digit;
            w_cnt_nxt        = 3'd1;
            w_b_nxt          = '0;
            w_neg_nxt        = 1'b0;
            w_state_nxt      = S_A;
            w_disp_value_nxt = w_digit;
            w_disp_neg_nxt   = 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.disp_value   = r_disp_value;
  assign bus.disp_neg     = r_disp_neg;
  assign bus.result_valid = r_result_valid;
  assign bus.state        = r_state;

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: directed key tables, an asynchronous reset
// sequence, then random keys against a string-based calculator model.
module tb_calc_sequencer;

  localparam int RES_W = 15;
  localparam int DIGITS = 4;
  localparam int MAXV = 9999;

  localparam int K_DIG  = 0;
  localparam int K_OP   = 1;
  localparam int K_EQU  = 2;
  localparam int K_CLR  = 3;
  localparam int K_NONE = 4;
  localparam int K_EOPN = 5;
  localparam int K_OPN  = 6;
  localparam int K_ALL  = 7;

  logic clk;
  logic rst_n;

  calc_sequencer_if #(.RES_W(RES_W)) bus ();

  calc_sequencer #(.DIGITS(DIGITS), .RES_W(RES_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic       kv;
    int         kind;
    logic [3:0] k;
    logic [1:0] opc;
    int         exp_disp;
    logic       exp_neg;
    logic       exp_rv;
    logic [1:0] exp_st;
  } vec_t;

  vec_t vecs[$];

  // scoreboard model state: operands are held as the digit strings typed
  string      m_a;
  string      m_b;
  bit         m_sub;
  int         m_res;
  bit         m_neg;
  int         m_phase;
  int         m_disp;
  bit         m_dneg;
  bit         m_rv;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic kv, input int kind, input logic [3:0] k, input logic [1:0] opc,
                         input int disp, input logic neg, input logic rv, input logic [1:0] st);
    vec_t v;
    v.kv = kv; v.kind = kind; v.k = k; v.opc = opc;
    v.exp_disp = disp; v.exp_neg = neg; v.exp_rv = rv; v.exp_st = st;
    vecs.push_back(v);
  endtask

  // driver tasks
  task automatic drive_raw(input logic kv, input logic c, input logic e, input logic o,
                           input logic n, input logic [3:0] k, input logic [1:0] opc);
    bus.key_valid   = kv;
    bus.is_c        = c;
    bus.is_equ      = e;
    bus.is_op       = o;
    bus.is_number   = n;
    bus.key_pressed = k;
    bus.operator    = opc;
  endtask

  task automatic drive_kind(input logic kv, input int kind, input logic [3:0] k, input logic [1:0] opc);
    case (kind)
      K_DIG:   drive_raw(kv, 1'b0, 1'b0, 1'b0, 1'b1, k, opc);
      K_OP:    drive_raw(kv, 1'b0, 1'b0, 1'b1, 1'b0, k, opc);
      K_EQU:   drive_raw(kv, 1'b0, 1'b1, 1'b0, 1'b0, k, opc);
      K_CLR:   drive_raw(kv, 1'b1, 1'b0, 1'b0, 1'b0, k, opc);
      K_EOPN:  drive_raw(kv, 1'b0, 1'b1, 1'b1, 1'b1, k, opc);
      K_OPN:   drive_raw(kv, 1'b0, 1'b0, 1'b1, 1'b1, k, opc);
      K_ALL:   drive_raw(kv, 1'b1, 1'b1, 1'b1, 1'b1, k, opc);
      default: drive_raw(kv, 1'b0, 1'b0, 1'b0, 1'b0, k, opc);
    endcase
  endtask

  task automatic model_clear();
    m_a = ""; m_b = ""; m_sub = 1'b0; m_res = 0; m_neg = 1'b0;
    m_phase = 0; m_disp = 0; m_dneg = 1'b0; m_rv = 1'b0;
  endtask

  // Calculator behaviour from the key rules: phase 0 A, 1 operator, 2 B, 3 result.
  task automatic model_apply(input logic c, input logic e, input logic o, input logic n,
                             input logic [3:0] k, input logic [1:0] opc);
    int av;
    int bv;
    string d;
    d = $sformatf("%0d", k);
    m_rv = 1'b0;
    if (c) begin
      model_clear();
    end else if (e) begin
      if (m_phase == 2) begin
        av = m_a.atoi();
        bv = m_b.atoi();
        if (!m_sub) begin
          m_res = av + bv; m_neg = 1'b0;
        end else if (av >= bv) begin
          m_res = av - bv; m_neg = 1'b0;
        end else begin
          m_res = bv - av; m_neg = 1'b1;
        end
        m_disp = m_res; m_dneg = m_neg; m_rv = 1'b1; m_phase = 3;
      end
    end else if (o) begin
      if (m_phase == 0 || m_phase == 1) begin
        m_sub = (opc == 2'b10); m_phase = 1;
      end else if (m_phase == 3 && !m_neg && m_res <= MAXV) begin
        m_a = $sformatf("%0d", m_res); m_sub = (opc == 2'b10); m_phase = 1;
      end
    end else if (n) begin
      case (m_phase)
        0: begin
          if (m_a.len() < DIGITS) m_a = {m_a, d};
          m_disp = m_a.atoi();
        end
        1: begin
          m_b = d; m_phase = 2; m_disp = m_b.atoi();
        end
        2: begin
          if (m_b.len() < DIGITS) m_b = {m_b, d};
          m_disp = m_b.atoi();
        end
        default: begin
          m_a = d; m_b = ""; m_neg = 1'b0; m_dneg = 1'b0; m_phase = 0;
          m_disp = m_a.atoi();
        end
      endcase
    end
  endtask

  task automatic check_outputs(input string tag, input int disp, input logic neg,
                               input logic rv, input logic [1:0] st);
    check({tag, "_disp_value"}, 32'(bus.disp_value), 32'(disp));
    check({tag, "_disp_neg"}, 32'(bus.disp_neg), 32'(neg));
    check({tag, "_result_valid"}, 32'(bus.result_valid), 32'(rv));
    check({tag, "_state"}, 32'(bus.state), 32'(st));
  endtask

  initial begin
    logic kv, c, e, o, n;
    logic [3:0] k;
    logic [1:0] opc;
    int r;

    rst_n = 1'b0;
    drive_raw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0);
    repeat (3) @(negedge clk);
    check_outputs("reset", 0, 1'b0, 1'b0, 2'b00);
    rst_n = 1'b1;

    // basic add, then result_valid drops on an idle cycle
    add_vec(1, K_DIG, 1, 0, 1, 0, 0, 0);
    add_vec(1, K_DIG, 2, 0, 12, 0, 0, 0);
    add_vec(1, K_OP, 0, 1, 12, 0, 0, 1);
    add_vec(1, K_DIG, 3, 0, 3, 0, 0, 2);
    add_vec(1, K_DIG, 4, 0, 34, 0, 0, 2);
    add_vec(1, K_EQU, 0, 0, 46, 0, 1, 3);
    add_vec(0, K_DIG, 5, 0, 46, 0, 0, 3);
    // negative result, blocked chain, new entry
    add_vec(1, K_DIG, 5, 0, 5, 0, 0, 0);
    add_vec(1, K_OP, 0, 2, 5, 0, 0, 1);
    add_vec(1, K_DIG, 9, 0, 9, 0, 0, 2);
    add_vec(1, K_EQU, 0, 0, 4, 1, 1, 3);
    add_vec(1, K_OP, 0, 1, 4, 1, 0, 3);
    add_vec(1, K_DIG, 7, 0, 7, 0, 0, 0);
    // digit limit and oversize result
    add_vec(1, K_CLR, 0, 0, 0, 0, 0, 0);
    add_vec(1, K_DIG, 1, 0, 1, 0, 0, 0);
    add_vec(1, K_DIG, 2, 0, 12, 0, 0, 0);
    add_vec(1, K_DIG, 3, 0, 123, 0, 0, 0);
    add_vec(1, K_DIG, 4, 0, 1234, 0, 0, 0);
    add_vec(1, K_DIG, 5, 0, 1234, 0, 0, 0);
    add_vec(1, K_OP, 0, 1, 1234, 0, 0, 1);
    add_vec(1, K_DIG, 9, 0, 9, 0, 0, 2);
    add_vec(1, K_DIG, 9, 0, 99, 0, 0, 2);
    add_vec(1, K_DIG, 9, 0, 999, 0, 0, 2);
    add_vec(1, K_DIG, 9, 0, 9999, 0, 0, 2);
    add_vec(1, K_DIG, 9, 0, 9999, 0, 0, 2);
    add_vec(1, K_EQU, 0, 0, 11233, 0, 1, 3);
    add_vec(1, K_OP, 0, 1, 11233, 0, 0, 3);
    // chained result
    add_vec(1, K_DIG, 8, 0, 8, 0, 0, 0);
    add_vec(1, K_OP, 0, 1, 8, 0, 0, 1);
    add_vec(1, K_DIG, 2, 0, 2, 0, 0, 2);
    add_vec(1, K_EQU, 0, 0, 10, 0, 1, 3);
    add_vec(1, K_OP, 0, 2, 10, 0, 0, 1);
    add_vec(1, K_DIG, 3, 0, 3, 0, 0, 2);
    add_vec(1, K_EQU, 0, 0, 7, 0, 1, 3);
    // clear mid-entry, ungated key ignored
    add_vec(1, K_DIG, 1, 0, 1, 0, 0, 0);
    add_vec(1, K_OP, 0, 1, 1, 0, 0, 1);
    add_vec(1, K_DIG, 2, 0, 2, 0, 0, 2);
    add_vec(1, K_CLR, 0, 0, 0, 0, 0, 0);
    add_vec(0, K_DIG, 5, 0, 0, 0, 0, 0);
    // ignored keys, flag priority, operator code 11 is add
    add_vec(1, K_DIG, 3, 0, 3, 0, 0, 0);
    add_vec(1, K_EQU, 0, 0, 3, 0, 0, 0);
    add_vec(1, K_NONE, 6, 0, 3, 0, 0, 0);
    add_vec(1, K_OPN, 9, 2, 3, 0, 0, 1);
    add_vec(1, K_EQU, 0, 0, 3, 0, 0, 1);
    add_vec(1, K_OP, 0, 3, 3, 0, 0, 1);
    add_vec(1, K_DIG, 5, 0, 5, 0, 0, 2);
    add_vec(1, K_OP, 0, 2, 5, 0, 0, 2);
    add_vec(1, K_EOPN, 1, 2, 8, 0, 1, 3);
    add_vec(1, K_ALL, 4, 2, 0, 0, 0, 0);
    // equal operands subtract, then chain a zero result
    add_vec(1, K_DIG, 5, 0, 5, 0, 0, 0);
    add_vec(1, K_OP, 0, 2, 5, 0, 0, 1);
    add_vec(1, K_DIG, 5, 0, 5, 0, 0, 2);
    add_vec(1, K_EQU, 0, 0, 0, 0, 1, 3);
    add_vec(1, K_OP, 0, 1, 0, 0, 0, 1);
    // entry interrupted by reset below
    add_vec(1, K_CLR, 0, 0, 0, 0, 0, 0);
    add_vec(1, K_DIG, 4, 0, 4, 0, 0, 0);
    add_vec(1, K_OP, 0, 1, 4, 0, 0, 1);
    add_vec(1, K_DIG, 6, 0, 6, 0, 0, 2);

    for (int i = 0; i < vecs.size(); i++) begin
      drive_kind(vecs[i].kv, vecs[i].kind, vecs[i].k, vecs[i].opc);
      @(posedge clk);
      @(negedge clk);
      check_outputs($sformatf("vec%0d", i), vecs[i].exp_disp, vecs[i].exp_neg,
                    vecs[i].exp_rv, vecs[i].exp_st);
    end

    // asynchronous reset between edges
    drive_raw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0);
    #2 rst_n = 1'b0;
    #1 check_outputs("async_rst", 0, 1'b0, 1'b0, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    drive_kind(1'b1, K_EQU, 4'd0, 2'd0);
    @(posedge clk);
    @(negedge clk);
    check_outputs("post_rst_equ", 0, 1'b0, 1'b0, 2'b00);

    // random keys against the model
    model_clear();
    for (int i = 0; i < 3000; i++) begin
      kv = ($urandom_range(0, 3) != 0);
      k = 4'($urandom_range(0, 9));
      opc = 2'($urandom_range(0, 3));
      r = $urandom_range(0, 99);
      c = 1'b0; e = 1'b0; o = 1'b0; n = 1'b0;
      if (r < 55)      n = 1'b1;
      else if (r < 75) o = 1'b1;
      else if (r < 88) e = 1'b1;
      else if (r < 92) c = 1'b1;
      else if (r < 96) ;
      else begin
        c = ($urandom_range(0, 3) == 0);
        e = 1'($urandom_range(0, 1));
        o = 1'($urandom_range(0, 1));
        n = 1'($urandom_range(0, 1));
      end
      drive_raw(kv, c, e, o, n, k, opc);
      if (kv) model_apply(c, e, o, n, k, opc);
      else    m_rv = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_outputs($sformatf("rnd%0d", i), m_disp, m_dneg, m_rv, 2'(m_phase));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
